// File: rtl/slave_bus_hub_pkg.sv
// Shared constants and types for the slave bus hub: local register map,
// error bit positions and the read pipeline entry.
package slave_bus_hub_pkg;

   localparam logic [1:0] REG_PENDING = 2'd0;
   localparam logic [1:0] REG_MASK    = 2'd1;
   localparam logic [1:0] REG_STATUS  = 2'd2;
   localparam logic [1:0] REG_VERSION = 2'd3;

   // Channel field in the pipeline is sized for the largest supported hub (16 channels).
   localparam int MAX_CH_BITS = 4;

   typedef enum logic [0:0] {
      ERR_WR_OOR = 1'b0,
      ERR_RD_OOR = 1'b1
   } err_bit_e;

   typedef struct packed {
      logic                   valid;
      logic                   is_local;
      logic                   oor;
      logic [MAX_CH_BITS-1:0] ch;
   } rd_entry_t;

endpackage

// File: rtl/slave_bus_hub_if.sv
// Virtual slave bus plus the fanned-out per-channel sub-slave bus.
// master = bus driver / sub-slave side, slave = the hub itself.
interface slave_bus_hub_if #(
   parameter int C_CH_COUNT      = 4,
   parameter int C_ADDR_BITS     = 16,
   parameter int C_SUB_ADDR_BITS = 12
);
   logic                       S_WE;
   logic [C_ADDR_BITS-1:0]     S_WADDR;
   logic [31:0]                S_WDATA;
   logic                       S_RE;
   logic [C_ADDR_BITS-1:0]     S_RADDR;
   logic [31:0]                S_RDATA;
   logic [C_CH_COUNT-1:0]      M_WE;
   logic [C_SUB_ADDR_BITS-1:0] M_WADDR;
   logic [31:0]                M_WDATA;
   logic [C_CH_COUNT-1:0]      M_RE;
   logic [C_SUB_ADDR_BITS-1:0] M_RADDR;
   logic [32*C_CH_COUNT-1:0]   M_RDATA;
   logic [C_CH_COUNT-1:0]      M_BUSY;
   logic [C_CH_COUNT-1:0]      M_INTR;
   logic                       BUSY;
   logic                       INTR;

   modport master (
      output S_WE, S_WADDR, S_WDATA, S_RE, S_RADDR, M_RDATA, M_BUSY, M_INTR,
      input  S_RDATA, M_WE, M_WADDR, M_WDATA, M_RE, M_RADDR, BUSY, INTR
   );

   modport slave (
      input  S_WE, S_WADDR, S_WDATA, S_RE, S_RADDR, M_RDATA, M_BUSY, M_INTR,
      output S_RDATA, M_WE, M_WADDR, M_WDATA, M_RE, M_RADDR, BUSY, INTR
   );
endinterface

// File: rtl/slave_bus_hub_regs.sv
// Local register block: PENDING (edge-set, W1C), MASK, ERR and the
// registered BUSY / INTR summaries.
module slave_bus_hub_regs
   import slave_bus_hub_pkg::*;
#(
   parameter int          C_CH_COUNT = 4,
   parameter logic [31:0] C_VERSION  = 32'h0001_0000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [1:0]            wr_idx,
   input  logic [C_CH_COUNT-1:0] wr_data,
   input  logic                  wr_oor,
   input  logic                  rd_oor,
   input  logic [1:0]            rd_idx,
   input  logic [C_CH_COUNT-1:0] m_busy,
   input  logic [C_CH_COUNT-1:0] m_intr,
   output logic [31:0]           rd_data,
   output logic                  busy,
   output logic                  intr
);

   logic [C_CH_COUNT-1:0] pending;
   logic [C_CH_COUNT-1:0] mask;
   logic [C_CH_COUNT-1:0] intr_prev;
   logic [C_CH_COUNT-1:0] rise;
   logic [C_CH_COUNT-1:0] pend_clr;
   logic [1:0]            err;
   logic [1:0]            err_set;
   logic [1:0]            err_clr;

   always_comb begin
      rise                 = m_intr & ~intr_prev;
      pend_clr             = (wr_en && (wr_idx == REG_PENDING)) ? wr_data : '0;
      err_clr              = (wr_en && (wr_idx == REG_STATUS)) ? 2'b11 : 2'b00;
      err_set              = 2'b00;
      err_set[ERR_WR_OOR]  = wr_oor;
      err_set[ERR_RD_OOR]  = rd_oor;
   end

   // New edges and error events are OR-ed in after the clear, so a set beats a same-cycle clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending   <= '0;
         mask      <= '0;
         intr_prev <= '0;
         err       <= 2'b00;
         busy      <= 1'b0;
         intr      <= 1'b0;
      end else begin
         pending   <= (pending & ~pend_clr) | rise;
         mask      <= (wr_en && (wr_idx == REG_MASK)) ? wr_data : mask;
         intr_prev <= m_intr;
         err       <= (err & ~err_clr) | err_set;
         busy      <= |m_busy;
         intr      <= |(pending & mask);
      end
   end

   always_comb begin
      rd_data = 32'h0;
      case (rd_idx)
         REG_PENDING: rd_data[C_CH_COUNT-1:0] = pending;
         REG_MASK:    rd_data[C_CH_COUNT-1:0] = mask;
         REG_STATUS: begin
            rd_data[C_CH_COUNT-1:0] = m_busy;
            rd_data[17:16]          = err;
         end
         REG_VERSION: rd_data = C_VERSION;
         default:     rd_data = 32'h0;
      endcase
   end

endmodule

// File: rtl/slave_bus_hub.sv
// Fans one virtual slave bus out to C_CH_COUNT sub-slaves by address decode;
// write path has 1-cycle latency, read return is aligned to 3 cycles.
module slave_bus_hub
   import slave_bus_hub_pkg::*;
#(
   parameter int          C_CH_COUNT      = 4,
   parameter int          C_ADDR_BITS     = 16,
   parameter int          C_SUB_ADDR_BITS = 12,
   parameter logic [31:0] C_VERSION       = 32'h0001_0000
) (
   input logic            CLK,
   input logic            RST,
   slave_bus_hub_if.slave bus
);

   localparam int CH_BITS = (C_CH_COUNT > 1) ? $clog2(C_CH_COUNT) : 1;
   localparam int HI_LSB  = C_SUB_ADDR_BITS + CH_BITS;
   // Bits strictly between the channel field and the local-select MSB must be zero.
   localparam logic [C_ADDR_BITS-1:0] HI_MASK =
      (C_ADDR_BITS'(1) << (C_ADDR_BITS - 1)) - (C_ADDR_BITS'(1) << HI_LSB);

   typedef struct packed {
      logic                       is_local;
      logic                       oor;
      logic [CH_BITS-1:0]         ch;
      logic [C_SUB_ADDR_BITS-1:0] offset;
   } dec_t;

   function automatic dec_t decode(input logic [C_ADDR_BITS-1:0] addr);
      dec_t d;
      d.is_local = addr[C_ADDR_BITS-1];
      d.ch       = addr[C_SUB_ADDR_BITS +: CH_BITS];
      d.offset   = addr[C_SUB_ADDR_BITS-1:0];
      d.oor      = !d.is_local && ((|(addr & HI_MASK)) || (int'(d.ch) >= C_CH_COUNT));
      return d;
   endfunction

   dec_t                    wdec;
   dec_t                    rdec;
   logic [C_CH_COUNT-1:0]   wsel;
   logic [C_CH_COUNT-1:0]   rsel;
   logic [31:0]             loc_rdata;
   logic                    reg_busy;
   logic                    reg_intr;
   rd_entry_t               rd1;
   rd_entry_t               rd2;
   logic [31:0]             ldata1;
   logic [31:0]             ldata2;

   always_comb begin
      wdec = decode(bus.S_WADDR);
      rdec = decode(bus.S_RADDR);
      wsel = (bus.S_WE && !wdec.is_local && !wdec.oor) ? (C_CH_COUNT'(1) << wdec.ch) : '0;
      rsel = (bus.S_RE && !rdec.is_local && !rdec.oor) ? (C_CH_COUNT'(1) << rdec.ch) : '0;
   end

   slave_bus_hub_regs #(
      .C_CH_COUNT (C_CH_COUNT),
      .C_VERSION  (C_VERSION)
   ) u_regs (
      .clk     (CLK),
      .rst     (RST),
      .wr_en   (bus.S_WE && wdec.is_local),
      .wr_idx  (wdec.offset[1:0]),
      .wr_data (bus.S_WDATA[C_CH_COUNT-1:0]),
      .wr_oor  (bus.S_WE && wdec.oor),
      .rd_oor  (bus.S_RE && rdec.oor),
      .rd_idx  (rdec.offset[1:0]),
      .m_busy  (bus.M_BUSY),
      .m_intr  (bus.M_INTR),
      .rd_data (loc_rdata),
      .busy    (reg_busy),
      .intr    (reg_intr)
   );

   assign bus.BUSY = reg_busy;
   assign bus.INTR = reg_intr;

   always_ff @(posedge CLK) begin
      if (RST) begin
         bus.M_WE    <= '0;
         bus.M_WADDR <= '0;
         bus.M_WDATA <= 32'h0;
      end else begin
         bus.M_WE    <= wsel;
         bus.M_WADDR <= bus.S_WE ? wdec.offset : bus.M_WADDR;
         bus.M_WDATA <= bus.S_WE ? bus.S_WDATA : bus.M_WDATA;
      end
   end

   // Local read data is captured at issue and carried alongside the channel entries to stay aligned.
   always_ff @(posedge CLK) begin
      if (RST) begin
         bus.M_RE    <= '0;
         bus.M_RADDR <= '0;
         rd1         <= '0;
         rd2         <= '0;
         ldata1      <= 32'h0;
         ldata2      <= 32'h0;
         bus.S_RDATA <= 32'h0;
      end else begin
         bus.M_RE    <= rsel;
         bus.M_RADDR <= bus.S_RE ? rdec.offset : bus.M_RADDR;
         rd1         <= '{valid: bus.S_RE, is_local: rdec.is_local, oor: rdec.oor,
                          ch: MAX_CH_BITS'(rdec.ch)};
         ldata1      <= loc_rdata;
         rd2         <= rd1;
         ldata2      <= ldata1;
         if (!rd2.valid) begin
            bus.S_RDATA <= bus.S_RDATA;
         end else if (rd2.is_local) begin
            bus.S_RDATA <= ldata2;
         end else if (rd2.oor) begin
            bus.S_RDATA <= 32'h0;
         end else begin
            bus.S_RDATA <= bus.M_RDATA[32*int'(rd2.ch) +: 32];
         end
      end
   end

endmodule
